// File: rtl/acc_cpu_core_if.sv
// Memory bus between the accumulator core (master) and its synchronous
// single-port memory (slave). Read data arrives one edge after the address.
interface acc_cpu_core_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: fetch, decode, optional indirect, execute,
// sequenced by a state counter and driving a one-cycle-latency memory.
module acc_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          run,
  acc_cpu_core_if.master bus,
  output logic [DW-1:0] ac,
  output logic          e_flag,
  output logic          zero,
  output logic [AW-1:0] pc,
  output logic [3:0]    sc,
  output logic          halted
);

  if (DW < AW + 4) begin : g_bad_param
    $error("acc_cpu_core: DW must be at least AW+4");
  end

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [3:0] {
    F0   = 4'd0,
    F1   = 4'd1,
    F2   = 4'd2,
    DEC  = 4'd3,
    IND0 = 4'd4,
    IND1 = 4'd5,
    EX0  = 4'd6,
    EX1  = 4'd7,
    EX2  = 4'd8,
    HALT = 4'd15
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ar, ar_nxt;
  logic [AW-1:0] pc_nxt;
  logic [DW-1:0] ir, ir_nxt;
  logic [DW-1:0] dr, dr_nxt;
  logic [DW-1:0] ac_nxt;
  logic          e_nxt;

  logic          ind;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic          is_mref;

  // Result is {E, AC}; ops that leave E alone pass the old carry through.
  function automatic logic [DW:0] alu(input logic [2:0]    f,
                                      input logic [DW-1:0] a,
                                      input logic [DW-1:0] b,
                                      input logic          c);
    logic [DW:0] r;
    case (f)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_XOR:  r = {c, a ^ b};
      OP_SHL:  r = {1'b0, a} + {1'b0, a};
      OP_LDA:  r = {c, b};
      OP_CMA:  r = {c, ~a};
      default: r = {c, a};
    endcase
    return r;
  endfunction

  assign ind     = ir[DW-1];
  assign op      = ir[DW-2:DW-4];
  assign addr    = ir[AW-1:0];
  assign is_mref = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
                   (op == OP_LDA) || (op == OP_STA);

  assign bus.mem_addr  = ar;
  assign bus.mem_wdata = ac;
  assign bus.mem_we    = (state == EX0) && (op == OP_STA);

  assign sc     = state;
  assign halted = (state == HALT);
  assign zero   = (ac == '0);

  always_comb begin
    state_nxt = state;
    ar_nxt    = ar;
    pc_nxt    = pc;
    ir_nxt    = ir;
    dr_nxt    = dr;
    ac_nxt    = ac;
    e_nxt     = e_flag;
    case (state)
      F0: begin
        if (run) begin
          ar_nxt    = pc;
          state_nxt = F1;
        end
      end
      F1: state_nxt = F2;
      F2: begin
        ir_nxt    = bus.mem_rdata;
        pc_nxt    = pc + 1'b1;
        state_nxt = DEC;
      end
      DEC: begin
        if (is_mref) begin
          ar_nxt    = addr;
          state_nxt = ind ? IND0 : EX0;
        end else if (op == OP_HLT) begin
          state_nxt = HALT;
        end else begin
          // SHL and CMA need no operand, so they retire straight from decode.
          {e_nxt, ac_nxt} = alu(op, ac, dr, e_flag);
          state_nxt       = F0;
        end
      end
      IND0: state_nxt = IND1;
      IND1: begin
        ar_nxt    = bus.mem_rdata[AW-1:0];
        state_nxt = EX0;
      end
      EX0: state_nxt = (op == OP_STA) ? F0 : EX1;
      EX1: begin
        dr_nxt    = bus.mem_rdata;
        state_nxt = EX2;
      end
      EX2: begin
        {e_nxt, ac_nxt} = alu(op, ac, dr, e_flag);
        state_nxt       = F0;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = F0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= F0;
      ar     <= '0;
      pc     <= '0;
      ir     <= '0;
      dr     <= '0;
      ac     <= '0;
      e_flag <= 1'b0;
    end else begin
      state  <= state_nxt;
      ar     <= ar_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      dr     <= dr_nxt;
      ac     <= ac_nxt;
      e_flag <= e_nxt;
    end
  end

endmodule
